fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one read in flight, 1-entry skid buffer, redirect restart.
// Optional jump predecode is enabled by defining FETCH_JUMP_PREDECODE_EN.
module fetch_sequencer #(
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned NUM_WORDS = 32
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic [31:0] o_mem_address,
   input  logic [31:0] i_mem_read_data,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_target,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   output logic        o_instr_valid
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HELD  = 2'd2,
      ST_REDIR = 2'd3
   } state_t;

   localparam logic [31:0] LP_LAST_PC  = 32'(NUM_WORDS - 1);
   localparam logic [31:0] LP_DEPTH    = 32'(NUM_WORDS);
   localparam logic [31:0] LP_RESET_PC = 32'(RESET_PC);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_fetch_pc;
   logic        r_req_valid;
   logic [31:0] r_req_pc;
   logic        r_skid_valid;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc;
   logic        r_instr_valid;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;

   logic        w_xfer;
   logic        w_out_free;
   logic        w_issue;
   logic        w_skid_load;
   logic        w_skid_drain;
   logic [31:0] w_pc_inc;
   logic        w_jump;
   logic [31:0] w_jump_target;

   // Handshake and issue qualifiers derived from the current state
   always_comb begin
      w_xfer       = r_instr_valid && !i_stall;
      w_out_free   = !r_instr_valid || w_xfer;
      w_issue      = ((r_state == ST_RUN) || (r_state == ST_REDIR)) && !r_skid_valid && w_out_free;
      w_skid_load  = r_req_valid && !w_out_free;
      w_skid_drain = r_skid_valid && w_xfer && !r_req_valid;
      if (r_fetch_pc == LP_LAST_PC) begin
         w_pc_inc = 32'd0;
      end else begin
         w_pc_inc = r_fetch_pc + 32'd1;
      end
   end

`ifdef FETCH_JUMP_PREDECODE_EN
   // A returning J-type word steers the fetch stream without waiting for Redirect
   assign w_jump        = r_req_valid && (i_mem_read_data[31:26] == 6'b000010);
   assign w_jump_target = {6'd0, i_mem_read_data[25:0]} % LP_DEPTH;
`else
   assign w_jump        = 1'b0;
   assign w_jump_target = 32'd0;
`endif

   // Next-state selection; Redirect overrides every state
   always_comb begin
      w_state_nxt = r_state;
      if (i_redirect) begin
         w_state_nxt = ST_REDIR;
      end else begin
         case (r_state)
            ST_BOOT:  w_state_nxt = ST_RUN;
            ST_RUN: begin
               if (w_skid_load) begin
                  w_state_nxt = ST_HELD;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_HELD: begin
               if (w_skid_drain) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_HELD;
               end
            end
            ST_REDIR: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_BOOT;
         endcase
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fetch address and in-flight request tracking
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fetch_pc  <= LP_RESET_PC;
         r_req_valid <= 1'b0;
         r_req_pc    <= 32'd0;
      end else if (i_redirect) begin
         r_fetch_pc  <= i_redirect_target % LP_DEPTH;
         r_req_valid <= 1'b0;
      end else if (w_jump) begin
         r_fetch_pc  <= w_jump_target;
         r_req_valid <= 1'b0;
      end else if (w_issue) begin
         r_req_valid <= 1'b1;
         r_req_pc    <= r_fetch_pc;
         r_fetch_pc  <= w_pc_inc;
      end else begin
         r_req_valid <= 1'b0;
      end
   end

   // Output register and skid buffer; returning data never overtakes the skid entry
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_instr_valid <= 1'b0;
         r_instr       <= 32'd0;
         r_instr_pc    <= 32'd0;
         r_skid_valid  <= 1'b0;
         r_skid_instr  <= 32'd0;
         r_skid_pc     <= 32'd0;
      end else if (i_redirect) begin
         r_instr_valid <= 1'b0;
         r_skid_valid  <= 1'b0;
      end else if (r_skid_valid && w_xfer) begin
         r_instr       <= r_skid_instr;
         r_instr_pc    <= r_skid_pc;
         r_instr_valid <= 1'b1;
         if (r_req_valid) begin
            r_skid_instr <= i_mem_read_data;
            r_skid_pc    <= r_req_pc;
         end else begin
            r_skid_valid <= 1'b0;
         end
      end else if (r_req_valid && w_out_free) begin
         r_instr       <= i_mem_read_data;
         r_instr_pc    <= r_req_pc;
         r_instr_valid <= 1'b1;
      end else if (r_req_valid) begin
         r_skid_instr  <= i_mem_read_data;
         r_skid_pc     <= r_req_pc;
         r_skid_valid  <= 1'b1;
      end else if (w_xfer) begin
         r_instr_valid <= 1'b0;
      end else begin
         r_instr_valid <= r_instr_valid;
      end
   end

   assign o_mem_address = r_fetch_pc;
   assign o_instr       = r_instr;
   assign o_instr_pc    = r_instr_pc;
   assign o_instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the expected stream is program order over the
// bench memory, restarted on reset/redirect; a negedge monitor checks every transfer.
module tb_fetch_sequencer;

   localparam int NW     = 32;
   localparam int RST_PC = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        i_reset;
   logic [31:0] o_mem_address;
   logic [31:0] mem_rdata;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_target;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        o_instr_valid;

   logic [31:0] mem [0:NW-1];
   exp_t        exp_q [$];
   int          gen_pc;
   int          tests;
   int          fails;

   fetch_sequencer #(.RESET_PC(RST_PC), .NUM_WORDS(NW)) dut (
      .i_clk             (clk),
      .i_reset           (i_reset),
      .o_mem_address     (o_mem_address),
      .i_mem_read_data   (mem_rdata),
      .i_stall           (i_stall),
      .i_redirect        (i_redirect),
      .i_redirect_target (i_redirect_target),
      .o_instr           (o_instr),
      .o_instr_pc        (o_instr_pc),
      .o_instr_valid     (o_instr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered instruction memory: address sampled at posedge, data next cycle
   always @(posedge clk) mem_rdata <= mem[int'(o_mem_address % 32'd32)];

   // Program-order successor of a word address
   function automatic int next_pc(input int pc);
`ifdef FETCH_JUMP_PREDECODE_EN
      if (mem[pc][31:26] == 6'b000010) return int'(mem[pc][25:0]) % NW;
`endif
      return (pc + 1) % NW;
   endfunction

   task automatic drive(input logic st, input logic rd, input logic [31:0] tg, input logic rs);
      i_stall           = st;
      i_redirect        = rd;
      i_redirect_target = tg;
      i_reset           = rs;
      if (rs) begin
         exp_q.delete();
         gen_pc = RST_PC;
      end else if (rd) begin
         exp_q.delete();
         gen_pc = int'(tg % 32'd32);
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back('{pc: 32'(gen_pc), instr: mem[gen_pc]});
         gen_pc = next_pc(gen_pc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Runs unstalled and records the next four delivered PCs
   task automatic expect_seq(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] got [4];
      logic [31:0] want [4];
      int n;
      n = 0;
      want = '{e0, e1, e2, e3};
      got  = '{32'd0, 32'd0, 32'd0, 32'd0};
      for (int c = 0; c < 16 && n < 4; c++) begin
         if (o_instr_valid) begin
            got[n] = o_instr_pc;
            n++;
         end
         drive(1'b0, 1'b0, 32'd0, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (k >= n || got[k] !== want[k]) begin
            fails++;
            $display("FAIL %s[%0d]: got pc=%0d (delivered %0d), expected pc=%0d", name, k, got[k], n, want[k]);
         end
      end
   endtask

   // Monitor: every transfer pops one expected entry; long unstalled silence is a failure
   initial begin : monitor
      exp_t e;
      int idle;
      idle = 0;
      forever begin
         @(negedge clk);
         if (i_reset || i_redirect || i_stall) begin
            idle = 0;
         end else if (o_instr_valid) begin
            idle = 0;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL stream: got pc=%0d, expected no delivery", o_instr_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_instr_pc !== e.pc || o_instr !== e.instr) begin
                  fails++;
                  $display("FAIL stream: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                           o_instr_pc, o_instr, e.pc, e.instr);
               end
            end
         end else begin
            idle++;
            if (idle > 6) begin
               tests++;
               fails++;
               $display("FAIL liveness: got %0d idle unstalled cycles, expected at most 6", idle);
               idle = 0;
            end
         end
      end
   end

   initial begin : stimulus
      tests = 0;
      fails = 0;
      gen_pc = RST_PC;
      for (int i = 0; i < NW; i++) mem[i] = 32'h2001_0100 + 32'(i);
      mem[0]  = 32'h2001_0001;
      mem[10] = 32'h0800_0010;
      mem[11] = 32'h2001_0001;

      drive(1'b0, 1'b0, 32'd0, 1'b1);
      check("rst_valid", 32'(o_instr_valid), 32'd0);
      check("rst_addr", o_mem_address, 32'(RST_PC));
      check("rst_instr", o_instr, 32'd0);
      check("rst_pc", o_instr_pc, 32'd0);
      for (int c = 0; c < 3; c++) begin
         check("boot_idle", 32'(o_instr_valid), 32'd0);
         drive(1'b0, 1'b0, 32'd0, 1'b0);
      end
      check("first_valid", 32'(o_instr_valid), 32'd1);
      check("first_instr", o_instr, 32'h2001_0001);
      check("first_pc", o_instr_pc, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check("pc2", o_instr_pc, 32'd2);

      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 1'b0, 32'd0, 1'b0);
         check("stall_instr", o_instr, mem[2]);
         check("stall_pc", o_instr_pc, 32'd2);
         check("stall_valid", 32'(o_instr_valid), 32'd1);
         check("stall_addr", o_mem_address, 32'd4);
      end
      expect_seq("release", 32'd2, 32'd3, 32'd4, 32'd5);

      drive(1'b0, 1'b1, 32'd30, 1'b0);
      expect_seq("wrap", 32'd30, 32'd31, 32'd0, 32'd1);

      drive(1'b1, 1'b0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b1, 32'd16, 1'b0);
      check("redir_drop", 32'(o_instr_valid), 32'd0);
      expect_seq("redirect", 32'd16, 32'd17, 32'd18, 32'd19);

      drive(1'b0, 1'b1, 32'd37, 1'b0);
      expect_seq("redir_mod", 32'd5, 32'd6, 32'd7, 32'd8);

      drive(1'b0, 1'b1, 32'd9, 1'b0);
`ifdef FETCH_JUMP_PREDECODE_EN
      expect_seq("jump", 32'd9, 32'd10, 32'd16, 32'd17);
`else
      expect_seq("jump", 32'd9, 32'd10, 32'd11, 32'd12);
`endif

      drive(1'b1, 1'b0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      check("held_rst_valid", 32'(o_instr_valid), 32'd0);
      check("held_rst_addr", o_mem_address, 32'(RST_PC));
      expect_seq("restart", 32'd0, 32'd1, 32'd2, 32'd3);

      for (int c = 0; c < 3000; c++) begin
         logic st, rd, rs;
         logic [31:0] tg;
         st = ($urandom_range(0, 99) < 35);
         rs = ($urandom_range(0, 299) == 0);
         rd = !rs && ($urandom_range(0, 99) < 3);
         tg = 32'($urandom_range(0, 63));
         drive(st, rd, tg, rs);
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
